// File: rtl/uart_parity_tx.sv
// uart_parity_tx: single-byte UART transmitter with a configurable parity bit.
// Frame: start (0), 8 data bits LSB first, parity, stop (1); each bit lasts
// BAUD_DIV clocks. The line is always driven from a register.
module uart_parity_tx #(
  parameter int unsigned CLK_FREQ  = 50,    // system clock in MHz
  parameter int unsigned BAUD_RATE = 9600,  // line baud rate
  parameter int unsigned CHECK_SEL = 1      // 1 = odd parity, 0 = even parity
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       uart_txd_o
);

  // Clocks per line bit; derived, not overridable.
  localparam int unsigned BAUD_DIV = (CLK_FREQ * 1000000) / BAUD_RATE;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;

  logic             baud_tick;
  logic             frame_parity;

  // Last clock of the current line bit.
  assign baud_tick = (cnt_q == CNT_MAX);

  // Parity of the byte being offered, in the selected sense.
  always_comb begin
    frame_parity = (CHECK_SEL != 0) ? ~^tx_data_i : ^tx_data_i;
  end

  // Baud counter: free-runs 0..BAUD_DIV-1 in every bit state, held at 0 when idle.
  always_comb begin
    cnt_d = '0;
    if (state_q != StIdle) begin
      cnt_d = baud_tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Next-state logic; the next line bit is registered on the same edge the state advances.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    txd_d     = txd_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (tx_valid_i) begin
          state_d   = StStart;
          shift_d   = tx_data_i;
          parity_d  = frame_parity;
          bit_idx_d = 3'd0;
          txd_d     = 1'b0;
        end
      end

      StStart: begin
        if (baud_tick) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end
      end

      StData: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = StParity;
            txd_d   = parity_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            // Bit 1 of the unshifted register is the next data bit on the line.
            txd_d     = shift_q[1];
          end
        end
      end

      StParity: begin
        if (baud_tick) begin
          state_d = StStop;
          txd_d   = 1'b1;
        end
      end

      StStop: begin
        if (baud_tick) begin
          state_d = StIdle;
          txd_d   = 1'b1;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready_o = (state_q == StIdle);
  assign tx_busy_o  = (state_q != StIdle);
  assign tx_done_o  = done_q;
  assign uart_txd_o = txd_q;

  // A divider below 2 leaves no room for a counted bit period.
  a_baud_div_min: assert property (@(posedge clk_i) BAUD_DIV >= 2)
    else $error("uart_parity_tx: BAUD_DIV must be at least 2");

  // Line idles high whenever no frame is active.
  a_idle_high: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StIdle) |-> txd_q);

  // Done only ever appears as an isolated pulse while idle.
  a_done_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    done_q |-> (state_q == StIdle));
  a_done_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    done_q |=> !done_q);

endmodule

// File: tb/tb_uart_parity_tx.sv
// tb_uart_parity_tx: drives an odd-parity and an even-parity instance with the same
// stimulus and checks both against a frame-age model every cycle, plus directed
// literal checks on captured frames.
module tb_uart_parity_tx;

  localparam int BD    = 4;        // 1 MHz / 250000 baud
  localparam int FRAME = 11 * BD;  // 44 cycles on the line

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic [1:0] ready_w, busy_w, done_w, txd_w;  // [0] odd parity, [1] even parity

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_parity_tx #(.CLK_FREQ(1), .BAUD_RATE(250000), .CHECK_SEL(1)) u_dut_odd (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (data),
    .tx_valid_i (valid),
    .tx_ready_o (ready_w[0]),
    .tx_busy_o  (busy_w[0]),
    .tx_done_o  (done_w[0]),
    .uart_txd_o (txd_w[0])
  );

  uart_parity_tx #(.CLK_FREQ(1), .BAUD_RATE(250000), .CHECK_SEL(0)) u_dut_even (
    .clk_i      (clk),
    .rst_i      (rst),
    .tx_data_i  (data),
    .tx_valid_i (valid),
    .tx_ready_o (ready_w[1]),
    .tx_busy_o  (busy_w[1]),
    .tx_done_o  (done_w[1]),
    .uart_txd_o (txd_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a frame is "age" cycles old (1 = first cycle after accept).
  bit          m_live = 1'b0;
  bit          m_on   = 1'b0;
  int          m_age  = 0;
  logic [10:0] m_frame [2];
  int          cyc    = 0;
  int          done_cyc [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_live <= 1'b1;
      m_on   <= 1'b0;
      m_age  <= 0;
    end else if (m_live) begin
      if (valid && (!m_on || m_age >= FRAME + 1)) begin
        m_on       <= 1'b1;
        m_age      <= 1;
        m_frame[0] <= {1'b1, ~^data, data, 1'b0};
        m_frame[1] <= {1'b1, ^data, data, 1'b0};
      end else if (m_on) begin
        m_age <= m_age + 1;
        if (m_age >= FRAME + 1) m_on <= 1'b0;
      end
    end
  end

  function automatic logic exp_busy();
    return m_on && m_age >= 1 && m_age <= FRAME;
  endfunction

  function automatic logic exp_done();
    return m_on && m_age == FRAME + 1;
  endfunction

  function automatic logic exp_line(input int i);
    if (!exp_busy()) return 1'b1;
    return m_frame[i][(m_age - 1) / BD];
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy[%0d]@%0d", i, cyc), busy_w[i], exp_busy());
        check($sformatf("ready[%0d]@%0d", i, cyc), ready_w[i], !exp_busy());
        check($sformatf("done[%0d]@%0d", i, cyc), done_w[i], exp_done());
        check($sformatf("txd[%0d]@%0d", i, cyc), txd_w[i], exp_line(i));
      end
      if (done_w[0] === 1'b1) done_cyc.push_back(cyc);
    end
  end

  // Offer a byte, then follow its frame for 45 cycles capturing mid-bit line samples.
  task automatic run_frame(input logic [7:0] d, input bit hold, input logic [7:0] nd,
                           input int poke, input int rst_at,
                           output logic [10:0] cap0, output logic [10:0] cap1,
                           output int done_at, output int busy_n, output int waited);
    cap0    = '1;
    cap1    = '1;
    done_at = 0;
    busy_n  = 0;
    waited  = 0;
    data    = d;
    valid   = 1'b1;
    while (ready_w[0] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", ready_w[0], 1'b1);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        valid = hold;
        if (hold) data = nd;
      end
      if (k == poke) begin
        data  = 8'h0F;
        valid = 1'b1;
      end
      if (k == poke + 1) valid = 1'b0;
      if (k % BD == 2) begin
        cap0[(k - 2) / BD] = txd_w[0];
        cap1[(k - 2) / BD] = txd_w[1];
      end
      if (busy_w[0] === 1'b1) busy_n++;
      if (done_w[0] === 1'b1 && done_at == 0) done_at = k;
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 1) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    logic [10:0] c0, c1;
    int da, bn, wt, cnt, nd0;

    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_ready", ready_w, 2'b11);
    check("idle_busy", busy_w, 2'b00);
    check("idle_txd", txd_w, 2'b11);

    // 0x55: popcount 4 -> odd parity bit 1, even parity bit 0.
    run_frame(8'h55, 1'b0, 8'h00, -1, -1, c0, c1, da, bn, wt);
    check("f55_odd", c0, 11'b11_01010101_0);
    check("f55_even", c1, 11'b10_01010101_0);
    check("f55_done_at", da, 45);
    check("f55_busy_cycles", bn, 44);

    // 0x07: popcount 3.
    run_frame(8'h07, 1'b0, 8'h00, -1, -1, c0, c1, da, bn, wt);
    check("f07_odd", c0, 11'b10_00000111_0);
    check("f07_even", c1, 11'b11_00000111_0);

    // 0x00: popcount 0.
    run_frame(8'h00, 1'b0, 8'h00, -1, -1, c0, c1, da, bn, wt);
    check("f00_odd", c0, 11'b11_00000000_0);
    check("f00_even", c1, 11'b10_00000000_0);

    // Back-to-back with valid held: 0xA5 then 0x3C.
    nd0 = done_cyc.size();
    run_frame(8'hA5, 1'b1, 8'h3C, -1, -1, c0, c1, da, bn, wt);
    check("fa5_odd", c0, 11'b11_10100101_0);
    check("fa5_even", c1, 11'b10_10100101_0);
    check("fa5_gap_line", txd_w, 2'b11);
    run_frame(8'h3C, 1'b0, 8'h00, -1, -1, c0, c1, da, bn, wt);
    check("f3c_immediate", wt, 0);
    check("f3c_odd", c0, 11'b11_00111100_0);
    check("f3c_even", c1, 11'b10_00111100_0);
    check("b2b_pulses", done_cyc.size() - nd0, 2);
    if (done_cyc.size() >= 2)
      check("b2b_spacing", done_cyc[done_cyc.size() - 1] - done_cyc[done_cyc.size() - 2], 45);

    // 0xF0 with a data change and a valid pulse mid-frame.
    run_frame(8'hF0, 1'b0, 8'h00, 10, -1, c0, c1, da, bn, wt);
    check("ff0_odd", c0, 11'b11_11110000_0);
    check("ff0_even", c1, 11'b10_11110000_0);
    check("ff0_busy_cycles", bn, 44);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_w !== 2'b00) cnt++;
    end
    check("ff0_no_extra_frame", cnt, 0);

    // Reset pulse during a data bit aborts the frame.
    run_frame(8'h5A, 1'b0, 8'h00, -1, 20, c0, c1, da, bn, wt);
    check("rst_txd", txd_w, 2'b11);
    check("rst_ready", ready_w, 2'b11);
    check("rst_no_done", da, 0);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_w !== 2'b00 || busy_w !== 2'b00) cnt++;
    end
    check("rst_quiet_after", cnt, 0);

    // 0x81 after the abort: popcount 2.
    run_frame(8'h81, 1'b0, 8'h00, -1, -1, c0, c1, da, bn, wt);
    check("f81_odd", c0, 11'b11_10000001_0);
    check("f81_even", c1, 11'b10_10000001_0);
    check("f81_done_at", da, 45);

    // Reset wins over a same-cycle accept.
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    check("rst_prio_txd", txd_w, 2'b11);
    check("rst_prio_busy", busy_w, 2'b00);
    rst   = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
